// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller and the forwarding unit.
package hazard_pkg;

  // Sequencing states of the hazard controller
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1,
    MEM_WAIT = 2'd2
  } hc_state_e;

  // Architectural zero register; a write to it never creates a dependency
  localparam logic [4:0] REG_X0 = 5'd0;

  // Operand source selects used by the forwarding unit
  localparam logic [1:0] FWD_RF = 2'b00;  // register file
  localparam logic [1:0] FWD_ME = 2'b01;  // bypass from ME
  localparam logic [1:0] FWD_WB = 2'b10;  // bypass from WB

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall/flush performance statistics.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count one per enabled cycle, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencing controller for the 5-stage core: memory-wait freeze,
// taken-branch squash, multi-cycle MDU hold and load-use bubble insertion.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_de,
  input  logic [4:0]       rs2_de,
  input  logic             use_rs2_de,
  input  logic [4:0]       rd_ex,
  input  logic             MemRd_ex,
  input  logic             branch_taken_ex,
  input  logic             mdu_start_ex,
  input  logic             mdu_done,
  input  logic             dmem_req_me,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exme_en,
  output logic             exme_flush,
  output logic             mewb_en,
  output logic             mdu_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(MDU_TIMEOUT + 1);

  hc_state_e         state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              done_seen, done_seen_next;
  logic              mdu_err_next;
  logic              frozen, load_use, mdu_timeout;

  // Hazard detection: memory freeze, load-use match and MDU watchdog expiry
  always_comb begin
    load_use = MemRd_ex && (rd_ex != REG_X0) &&
               ((rd_ex == rs1_de) || (use_rs2_de && (rd_ex == rs2_de)));
    // Once waiting, only dmem_ready releases the freeze
    frozen = (state == MEM_WAIT) ? !dmem_ready : (dmem_req_me && !dmem_ready);
    mdu_timeout = (state == MDU_BUSY) && (wait_cnt == WAIT_W'(MDU_TIMEOUT));
  end

  // Next-state and stage-control decode, highest priority first
  always_comb begin
    pc_en          = 1'b1;
    ifid_en        = 1'b1;
    ifid_flush     = 1'b0;
    idex_en        = 1'b1;
    idex_flush     = 1'b0;
    exme_en        = 1'b1;
    exme_flush     = 1'b0;
    mewb_en        = 1'b1;
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    done_seen_next = done_seen;
    mdu_err_next   = mdu_err;

    if (frozen) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_en = 1'b0;
      exme_en = 1'b0;
      mewb_en = 1'b0;
      // An MDU stays busy across the freeze; a RUN freeze parks in MEM_WAIT
      if (state == RUN) begin
        state_next = MEM_WAIT;
      end
      // Remember a completion that lands while nothing can capture it
      if ((state == MDU_BUSY) && mdu_done) begin
        done_seen_next = 1'b1;
      end
    end else begin
      case (state)
        MDU_BUSY: begin
          if (mdu_done || done_seen || mdu_timeout) begin
            // Pipeline advances so EX/ME captures the MDU result
            state_next     = RUN;
            wait_cnt_next  = '0;
            done_seen_next = 1'b0;
            if (mdu_timeout) begin
              mdu_err_next = 1'b1;
            end
          end else begin
            pc_en         = 1'b0;
            ifid_en       = 1'b0;
            idex_en       = 1'b0;
            exme_flush    = 1'b1;
            wait_cnt_next = wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          // RUN, or the cycle MEM_WAIT is released: re-evaluate events
          state_next = RUN;
          if (branch_taken_ex) begin
            // Wrong-path instructions in IF/DE and DE/EX are discarded
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (mdu_start_ex) begin
            state_next    = MDU_BUSY;
            wait_cnt_next = '0;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
      endcase
    end

    // Held in reset: freeze every stage and present NOPs downstream
    if (!rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exme_en    = 1'b0;
      mewb_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exme_flush = 1'b1;
    end
  end

  // Controller state, MDU watchdog, deferred-done flag and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      done_seen <= 1'b0;
      mdu_err   <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      done_seen <= done_seen_next;
      mdu_err   <= mdu_err_next;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_en),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ifid_flush || idex_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with immediate-assertion checking.
module tb_hazard_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_de, rs2_de, rd_ex;
  logic        use_rs2_de, MemRd_ex, branch_taken_ex, mdu_start_ex, mdu_done;
  logic        dmem_req_me, dmem_ready;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        exme_en, exme_flush, mewb_en, mdu_err;
  logic [31:0] stall_count, flush_count;

  // Small standalone counter to exercise saturation
  logic        sat_rst_n, sat_inc;
  logic [2:0]  sat_count;

  int n_vec = 0;
  int n_err = 0;

  // Expected stage-control words: {pc_en, ifid_en, ifid_flush, idex_en,
  // idex_flush, exme_en, exme_flush, mewb_en}
  localparam logic [7:0] O_DEF    = 8'b11010101;
  localparam logic [7:0] O_RST    = 8'b00101010;
  localparam logic [7:0] O_FREEZE = 8'b00000000;
  localparam logic [7:0] O_LU     = 8'b00011101;
  localparam logic [7:0] O_BR     = 8'b11111101;
  localparam logic [7:0] O_MDU    = 8'b00000111;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.CNT_W(32), .MDU_TIMEOUT(64)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rs1_de          (rs1_de),
    .rs2_de          (rs2_de),
    .use_rs2_de      (use_rs2_de),
    .rd_ex           (rd_ex),
    .MemRd_ex        (MemRd_ex),
    .branch_taken_ex (branch_taken_ex),
    .mdu_start_ex    (mdu_start_ex),
    .mdu_done        (mdu_done),
    .dmem_req_me     (dmem_req_me),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_en         (idex_en),
    .idex_flush      (idex_flush),
    .exme_en         (exme_en),
    .exme_flush      (exme_flush),
    .mewb_en         (mewb_en),
    .mdu_err         (mdu_err),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  sat_counter #(.W(3)) u_sat (
    .clk   (clk),
    .rst_n (sat_rst_n),
    .inc   (sat_inc),
    .count (sat_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exme_en, exme_flush, mewb_en};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("vec %0d %s ctl=%b", n_vec, tag, obs);
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("vec %0d %s val=%0d", n_vec, tag, obs);
  endtask

  task automatic clear_inputs;
    rs1_de = 5'd0; rs2_de = 5'd0; rd_ex = 5'd0; use_rs2_de = 1'b0;
    MemRd_ex = 1'b0; branch_taken_ex = 1'b0; mdu_start_ex = 1'b0;
    mdu_done = 1'b0; dmem_req_me = 1'b0; dmem_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    sat_rst_n = 1'b0;
    sat_inc = 1'b0;
    clear_inputs();
    #2;
    chk_ctl("reset_outputs", O_RST);
    chk_val("reset_stall_cnt", stall_count, 0);
    chk_val("reset_flush_cnt", flush_count, 0);
    chk_val("reset_mdu_err", {31'd0, mdu_err}, 0);

    // Release reset between edges; default outputs from the same cycle
    tick; rst_n = 1'b1; sat_rst_n = 1'b1;
    #1 chk_ctl("run_default", O_DEF);

    // Load x5 in EX, consumer reads x5 through rs1: exactly one bubble
    tick; MemRd_ex = 1'b1; rd_ex = 5'd5; rs1_de = 5'd5;
    #1 chk_ctl("loaduse_rs1", O_LU);
    tick; clear_inputs();
    #1 chk_ctl("loaduse_after", O_DEF);
    chk_val("loaduse_stall_cnt", stall_count, 1);
    chk_val("loaduse_flush_cnt", flush_count, 1);

    // x0 destination never stalls
    tick; MemRd_ex = 1'b1; rd_ex = 5'd0; rs1_de = 5'd0;
    #1 chk_ctl("loaduse_x0", O_DEF);
    // rs2 match ignored when rs2 is unused, honoured when used
    tick; rd_ex = 5'd5; rs1_de = 5'd3; rs2_de = 5'd5; use_rs2_de = 1'b0;
    #1 chk_ctl("loaduse_rs2_unused", O_DEF);
    tick; use_rs2_de = 1'b1;
    #1 chk_ctl("loaduse_rs2_used", O_LU);
    tick; clear_inputs();
    #1 chk_val("rs2_stall_cnt", stall_count, 2);

    // Taken branch overrides a simultaneous load-use match
    tick; branch_taken_ex = 1'b1; MemRd_ex = 1'b1; rd_ex = 5'd5; rs1_de = 5'd5;
    #1 chk_ctl("branch_over_lu", O_BR);
    tick; clear_inputs();
    #1 chk_ctl("branch_after", O_DEF);
    chk_val("branch_stall_cnt", stall_count, 2);
    chk_val("branch_flush_cnt", flush_count, 3);

    // MDU op: five busy cycles, done in the sixth
    tick; mdu_start_ex = 1'b1;
    #1 chk_ctl("mdu_start", O_DEF);
    for (int i = 1; i <= 5; i++) begin
      tick; mdu_start_ex = (i == 3);  // a start while busy is ignored
      #1 chk_ctl($sformatf("mdu_busy_%0d", i), O_MDU);
    end
    tick; mdu_start_ex = 1'b0; mdu_done = 1'b1;
    #1 chk_ctl("mdu_done_cycle", O_DEF);
    tick; mdu_done = 1'b0;
    #1 chk_ctl("mdu_back_run", O_DEF);
    chk_val("mdu_stall_cnt", stall_count, 7);
    chk_val("mdu_flush_cnt", flush_count, 3);

    // MDU with a 3-cycle memory freeze; done arrives in frozen cycle 2
    tick; mdu_start_ex = 1'b1;
    #1 chk_ctl("mdu2_start", O_DEF);
    tick; mdu_start_ex = 1'b0;
    #1 chk_ctl("mdu2_busy", O_MDU);
    for (int i = 1; i <= 3; i++) begin
      tick; dmem_req_me = 1'b1; dmem_ready = 1'b0;
      mdu_done = (i == 2); branch_taken_ex = (i == 1);
      #1 chk_ctl($sformatf("mdu2_frozen_%0d", i), O_FREEZE);
    end
    tick; clear_inputs();
    #1 chk_ctl("mdu2_done_seen_exit", O_DEF);
    tick;
    #1 chk_ctl("mdu2_back_run", O_DEF);
    chk_val("mdu2_err", {31'd0, mdu_err}, 0);
    chk_val("mdu2_stall_cnt", stall_count, 11);

    // Freeze from RUN: MEM_WAIT holds until dmem_ready regardless of req
    tick; dmem_req_me = 1'b1; dmem_ready = 1'b0;
    #1 chk_ctl("memwait_enter", O_FREEZE);
    tick; dmem_req_me = 1'b0;
    #1 chk_ctl("memwait_hold", O_FREEZE);
    tick; dmem_ready = 1'b1;
    #1 chk_ctl("memwait_release", O_DEF);
    tick; dmem_ready = 1'b0;
    #1 chk_ctl("memwait_back_run", O_DEF);
    chk_val("memwait_stall_cnt", stall_count, 13);

    // MDU never completes: 64 stall cycles, then a timeout exit
    tick; mdu_start_ex = 1'b1;
    #1 chk_ctl("mdu3_start", O_DEF);
    for (int i = 1; i <= 64; i++) begin
      tick; mdu_start_ex = 1'b0;
      #1 chk_ctl($sformatf("mdu3_busy_%0d", i), O_MDU);
    end
    tick;
    #1 chk_ctl("mdu3_timeout_exit", O_DEF);
    chk_val("mdu3_err_before_edge", {31'd0, mdu_err}, 0);
    tick;
    #1 chk_ctl("mdu3_back_run", O_DEF);
    chk_val("mdu3_err_set", {31'd0, mdu_err}, 1);
    chk_val("mdu3_stall_cnt", stall_count, 77);

    // Reset pulse in the middle of an MDU op
    tick; mdu_start_ex = 1'b1;
    tick; mdu_start_ex = 1'b0;
    #1 chk_ctl("mdu4_busy", O_MDU);
    chk_val("mdu4_err_sticky", {31'd0, mdu_err}, 1);
    tick;
    rst_n = 1'b0;
    #1 chk_ctl("async_reset_outputs", O_RST);
    tick;
    #1 chk_ctl("reset_held", O_RST);
    tick; rst_n = 1'b1;
    #1 chk_ctl("post_reset_run", O_DEF);
    chk_val("post_reset_err", {31'd0, mdu_err}, 0);
    chk_val("post_reset_stall_cnt", stall_count, 0);
    chk_val("post_reset_flush_cnt", flush_count, 0);

    // Counter saturation on a 3-bit instance
    tick; sat_inc = 1'b1;
    for (int i = 0; i < 7; i++) tick;
    chk_val("sat_reach_max", {29'd0, sat_count}, 7);
    for (int i = 0; i < 3; i++) tick;
    chk_val("sat_hold_max", {29'd0, sat_count}, 7);
    sat_inc = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core: IF, DE, EX, ME, WB.
- Drives the stage-register enables and flushes (stall/bubble/squash) for four cases:
  - load-use hazards
  - taken branches/jumps resolved in EX
  - multi-cycle MDU operations
  - data-memory wait states
- Sits beside the forwarding logic. Forwarding covers ALU-to-ALU dependencies; this block covers everything that needs a pipeline freeze or a bubble.
- Also keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 32, width of the performance counters.
- MDU_TIMEOUT, 64, maximum MDU_BUSY cycles before the error abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_de  in  5  rs1 of the instruction in DE.
- rs2_de  in  5  rs2 of the instruction in DE.
- use_rs2_de  in  1  DE instruction actually reads rs2.
- rd_ex  in  5  destination register of the EX instruction.
- MemRd_ex  in  1  EX instruction is a load.
- branch_taken_ex  in  1  taken branch/jump resolved in EX.
- mdu_start_ex  in  1  EX instruction starts a multi-cycle mul/div.
- mdu_done  in  1  MDU result valid; 1-cycle pulse.
- dmem_req_me  in  1  ME stage accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/DE register enable.
- ifid_flush  out  1  IF/DE register clear to NOP.
- idex_en  out  1  DE/EX register enable.
- idex_flush  out  1  DE/EX register clear to NOP.
- exme_en  out  1  EX/ME register enable.
- exme_flush  out  1  EX/ME register clear to NOP.
- mewb_en  out  1  ME/WB register enable.
- mdu_err  out  1  sticky MDU timeout flag.
- stall_count  out  CNT_W  cycles with pc_en=0.
- flush_count  out  CNT_W  cycles with ifid_flush or idex_flush asserted.

Behaviour:
- FSM states (registered): RUN, MDU_BUSY, MEM_WAIT. Reset state: RUN.
- Reset:
  - While rst_n=0: all *_en=0; ifid_flush, idex_flush, exme_flush=1; mdu_err=0; counters=0; wait counter=0; done_seen=0.
  - After release, outputs follow the rules below starting the same cycle.
- Default (RUN, no event): all *_en=1, all flushes=0.
- Freeze (highest priority):
  - Condition: (dmem_req_me && !dmem_ready) in RUN, or MEM_WAIT && !dmem_ready.
  - Outputs: all *_en=0, all flushes=0.
  - RUN→MEM_WAIT on the freeze condition. MEM_WAIT→RUN in the cycle dmem_ready=1; that cycle gives default outputs.
  - Branch, load-use and MDU inputs are ignored while frozen; they are re-evaluated when the freeze lifts.
- Branch squash (priority 2, RUN only):
  - branch_taken_ex=1 → ifid_flush=1, idex_flush=1, everything else default.
  - Overrides load-use, because the load-use consumer is on the wrong path.
- MDU (priority 3):
  - RUN && mdu_start_ex → next state MDU_BUSY; outputs this cycle are default.
  - In MDU_BUSY: pc_en, ifid_en, idex_en=0; exme_flush=1 (bubbles drain into ME/WB); mewb_en=1.
  - MDU_BUSY exit on (mdu_done || done_seen): default outputs that cycle so the result is captured in EX/ME; next state RUN.
  - mdu_done arriving while frozen sets the done_seen register; done_seen clears on exit.
  - Wait counter increments each non-frozen MDU_BUSY cycle. At MDU_TIMEOUT: set mdu_err (sticky until reset), exit as if done.
  - mdu_start_ex is ignored outside RUN.
- Load-use (priority 4, RUN only):
  - Condition: MemRd_ex && rd_ex!=0 && (rd_ex==rs1_de || (use_rs2_de && rd_ex==rs2_de)).
  - Outputs: pc_en=0, ifid_en=0, idex_flush=1. Exactly one bubble; the next cycle re-evaluates.
  - rd_ex=0 never stalls.
- Counters:
  - Increment on the rising edge when their condition holds.
  - Saturate at 2^CNT_W-1 with no wrap.
  - Not incremented while rst_n=0.
- Latency: all enables/flushes are combinational from the inputs plus the registered state; no added pipeline delay.

Decomposition:
- hazard_pkg holds:
  - the state enum (RUN, MDU_BUSY, MEM_WAIT)
  - the x0 register constant
  - the 2-bit forwarding-select encodings shared with the forwarding unit (00 reg file, 01 from ME, 10 from WB)
- Sub-module sat_counter (parameter W; inputs inc, clk, rst_n) is instantiated twice for the performance counters.

Test Plan:
- Load x5 in EX (MemRd_ex=1, rd_ex=5), rs1_de=5 → exactly one cycle pc_en=0, ifid_en=0, idex_flush=1, then default; stall_count=1.
- Same as above with rd_ex=0, or with rs2_de=5 and use_rs2_de=0 → no stall.
- branch_taken_ex=1 together with a load-use match → ifid_flush=idex_flush=1, pc_en=1; flush_count=1, stall_count=0.
- mdu_start_ex, then mdu_done after 5 cycles → 5 cycles with pc_en=0 and exme_flush=1, default outputs in the done cycle, state RUN, stall_count=5.
- dmem_req_me=1, dmem_ready=0 for 3 cycles during MDU_BUSY, with mdu_done pulsing in frozen cycle 2 → all enables 0 for 3 cycles; exit to RUN in the first non-frozen MDU_BUSY cycle (via done_seen); mdu_err=0.
- MDU with no mdu_done → exit after 64 non-frozen MDU_BUSY cycles with mdu_err=1. Then pulse rst_n low mid-MDU_BUSY → all enables 0 and flushes 1 during reset; state RUN, mdu_err=0, counters 0 after release.
